ifu_fetch_queue: RTL and testbench
==================================

IFU_FETCH_QUEUE -- requirements
Module: ifu_fetch_queue

Interface
REQ-001 Parameter DATA_W, 64: memory data bus and PC width.
REQ-002 Parameter INST_W, 32: instruction width; DATA_W SHALL equal 2*INST_W.
REQ-003 Parameter DEPTH, 4: queue entries; power of two, >=2.
REQ-004 Parameter RESET_PC, 64'h8000_0000: first fetch address after reset.
REQ-005 fq_clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 fq_rst_i  in  1  synchronous, active-high reset.
REQ-007 fq_req_valid_o  out  1  fetch request valid; fq_req_ready_i  in  1  memory accepts request.
REQ-008 fq_req_addr_o  out  DATA_W  fetch address, bits [2:0] always zero.
REQ-009 fq_rsp_valid_i  in  1  response valid; fq_rsp_data_i  in  DATA_W  fetched doubleword.
REQ-010 fq_trap_flag_i  in  1 and fq_trap_dnpc_i  in  DATA_W: trap redirect and target.
REQ-011 fq_branch_flag_i  in  1 and fq_branch_dnpc_i  in  DATA_W: branch redirect and target.
REQ-012 fq_inst_valid_o  out  1, fq_inst_ready_i  in  1: instruction handshake to EXU.
REQ-013 fq_inst_o  out  INST_W and fq_pc_o  out  DATA_W: head instruction and its PC.
REQ-014 fq_misalign_o  out  1: sticky misaligned-target flag (exists only under FQ_MISALIGN_CHK_EN).

Function
REQ-015 FSM states: REQ (fq_req_valid_o=1), WAIT (one request outstanding), HALT (misalign only); at most one outstanding request.
REQ-016 REQ->WAIT on fq_req_valid_o&&fq_req_ready_i; WAIT->REQ on fq_rsp_valid_i; fq_rsp_valid_i outside WAIT ignored.
REQ-017 In REQ, fq_req_valid_o SHALL assert only when >=2 queue entries are free; fq_req_addr_o = {fetch_pc[DATA_W-1:3],3'b0}.
REQ-018 On accepted response with fetch_pc[2]=0: push {fetch_pc, data[31:0]} then {fetch_pc+4, data[63:32]}; fetch_pc += 8.
REQ-019 On accepted response with fetch_pc[2]=1: push only {fetch_pc, data[63:32]}; fetch_pc += 4.
REQ-020 Response accepted at cycle N SHALL appear on fq_inst_o/fq_pc_o at N+1 when queue was empty.
REQ-021 Head pops on fq_inst_valid_o&&fq_inst_ready_i; push and pop in same cycle both take effect; count never exceeds DEPTH, pointers wrap modulo DEPTH.
REQ-022 fq_inst_valid_o = queue non-empty; fq_inst_o/fq_pc_o stable while valid and not ready.
REQ-023 Redirect (trap or branch): trap target wins over branch; queue flushed, fetch_pc loaded with target, effective next cycle; a pop in the same cycle is discarded.
REQ-024 Redirect in WAIT SHALL set drop_pending; the next response is discarded (no push), then FSM returns to REQ with new fetch_pc.
REQ-025 Redirect coincident with fq_rsp_valid_i SHALL discard that response; drop_pending not set.
REQ-026 Redirect in REQ while request is being accepted: FSM enters WAIT with drop_pending set.
REQ-027 Without misalign check, target bits [1:0] SHALL be forced to zero.

Reset
REQ-028 While fq_rst_i=1: fetch_pc=RESET_PC, state REQ, queue empty, drop_pending=0, fq_misalign_o=0; fq_req_valid_o=0, fq_inst_valid_o=0.
REQ-029 First cycle after fq_rst_i deasserts, fq_req_valid_o=1 with addr RESET_PC.
REQ-030 Reset asserted mid-WAIT SHALL abandon the outstanding response; responses during reset ignored.

Configuration
REQ-031 Macro FQ_MISALIGN_CHK_EN defined: redirect target with [1:0]!=0 sets fq_misalign_o, flushes queue, enters HALT (no requests) until next aligned redirect, which clears fq_misalign_o.
REQ-032 FQ_MISALIGN_CHK_EN undefined: no fq_misalign_o port, no HALT state, REQ-027 applies.

Structure
REQ-033 RESET_PC default, DataBus/InstBus widths and FSM state encodings SHALL live in the shared defines include.
REQ-034 Queue SHALL be sub-module ifu_fetch_fifo: synchronous, 1-or-2 push, 1 pop, flush, free-count output.

Verification
REQ-035 Reset release, memory ready=1, rsp 1 cycle later data 64'hBBBB_BBBB_AAAA_AAAA -> PCs 0x8000_0000 (AAAA_AAAA), 0x8000_0004 (BBBB_BBBB).
REQ-036 Branch to 0x8000_0104 -> single push of data[63:32] at PC 0x8000_0104, next request addr 0x8000_0108.
REQ-037 fq_inst_ready_i=0 with DEPTH=4 -> after 4 entries fq_req_valid_o stays 0; one pop with 3 held still blocks; second pop re-enables.
REQ-038 Branch 0x100 in WAIT, rsp next cycle -> response dropped, next request addr 0x100, no stale PC on output.
REQ-039 Trap 0x200 and branch 0x300 same cycle -> next request addr 0x200, queue empty next cycle.
REQ-040 With FQ_MISALIGN_CHK_EN, branch 0x102 -> fq_misalign_o=1, no requests; trap 0x200 -> flag clears, request 0x200.

Source files
------------

// File: rtl/ifu_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: bus widths, the
// default reset PC and the fetch FSM state encoding.
// The HALT state exists only when FQ_MISALIGN_CHK_EN is defined.
package ifu_fetch_queue_pkg;

  localparam int          FQ_DATA_BUS_W = 64;
  localparam int          FQ_INST_BUS_W = 32;
  localparam logic [63:0] FQ_RESET_PC   = 64'h8000_0000;

  typedef enum logic [1:0] {
    FQ_ST_REQ  = 2'd0,
`ifdef FQ_MISALIGN_CHK_EN
    FQ_ST_WAIT = 2'd1,
    FQ_ST_HALT = 2'd2
`else
    FQ_ST_WAIT = 2'd1
`endif
  } fq_state_e;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Fetch instruction FIFO: one or two pushes and one pop per cycle, a flush
// that empties it, and a free-entry count for request throttling.
// The caller never pushes more than the free count allows.
module ifu_fetch_fifo #(
  parameter  int WIDTH = 96,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push0_i,
  input  logic             push1_i,
  input  logic [WIDTH-1:0] push0_data_i,
  input  logic [WIDTH-1:0] push1_data_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    free_o
);

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_pop;
  logic             do_push1;
  logic [CW-1:0]    push_cnt;

  // Next pointers, occupancy and storage; flush wins over any push or pop.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push1 = push0_i && push1_i;
    push_cnt = CW'(push0_i) + CW'(do_push1);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      wr_ptr_d = wr_ptr_q + AW'(push_cnt);
      count_d  = count_q + push_cnt - CW'(do_pop);
      if (push0_i)  mem_d[wr_ptr_q]           = push0_data_i;
      if (do_push1) mem_d[wr_ptr_q + AW'(1)]  = push1_data_i;
    end
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign free_o  = CW'(DEPTH) - count_q;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit front end: issues aligned doubleword fetches with
// one request outstanding, splits responses into instructions, queues them
// for the EXU and handles trap/branch redirects.
// Optional macro FQ_MISALIGN_CHK_EN adds the sticky fq_misalign_o flag and a
// HALT state entered on a redirect to a target with nonzero bits [1:0].
module ifu_fetch_queue
  import ifu_fetch_queue_pkg::*;
#(
  parameter int                DATA_W   = FQ_DATA_BUS_W,
  parameter int                INST_W   = FQ_INST_BUS_W,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(FQ_RESET_PC)
) (
  input  logic              fq_clk_i,
  input  logic              fq_rst_i,
  output logic              fq_req_valid_o,
  input  logic              fq_req_ready_i,
  output logic [DATA_W-1:0] fq_req_addr_o,
  input  logic              fq_rsp_valid_i,
  input  logic [DATA_W-1:0] fq_rsp_data_i,
  input  logic              fq_trap_flag_i,
  input  logic [DATA_W-1:0] fq_trap_dnpc_i,
  input  logic              fq_branch_flag_i,
  input  logic [DATA_W-1:0] fq_branch_dnpc_i,
  output logic              fq_inst_valid_o,
  input  logic              fq_inst_ready_i,
  output logic [INST_W-1:0] fq_inst_o,
  output logic [DATA_W-1:0] fq_pc_o
`ifdef FQ_MISALIGN_CHK_EN
  ,
  output logic              fq_misalign_o
`endif
);

  localparam int EW = DATA_W + INST_W;
  localparam int CW = $clog2(DEPTH) + 1;

  fq_state_e         state_q, state_d;
  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              drop_q, drop_d;
  logic              redirect;
  logic [DATA_W-1:0] target_raw;
  logic [DATA_W-1:0] target;
  logic              req_fire;
  logic              rsp_acc;
  logic              push0, push1, pop;
  logic [EW-1:0]     push0_data, push1_data, head;
  logic              fifo_empty;
  logic [CW-1:0]     free_cnt;
`ifdef FQ_MISALIGN_CHK_EN
  logic              misalign_q, misalign_d;
  logic              target_bad;
`endif

  // Redirect selection: a trap target takes priority over a branch target.
  always_comb begin
    redirect   = fq_trap_flag_i || fq_branch_flag_i;
    target_raw = fq_trap_flag_i ? fq_trap_dnpc_i : fq_branch_dnpc_i;
`ifdef FQ_MISALIGN_CHK_EN
    target     = target_raw;
    target_bad = redirect && (target_raw[1:0] != 2'b00);
`else
    target     = target_raw & ~DATA_W'(3);
`endif
  end

  // Request/response handshakes and the entries built from a response.
  always_comb begin
    fq_req_valid_o  = !fq_rst_i && (state_q == FQ_ST_REQ) && (free_cnt >= CW'(2));
    fq_req_addr_o   = {fetch_pc_q[DATA_W-1:3], 3'b000};
    fq_inst_valid_o = !fq_rst_i && !fifo_empty;
    fq_pc_o         = head[EW-1:INST_W];
    fq_inst_o       = head[INST_W-1:0];
    req_fire        = fq_req_valid_o && fq_req_ready_i;
    rsp_acc         = !fq_rst_i && (state_q == FQ_ST_WAIT) && fq_rsp_valid_i;
    push0           = rsp_acc && !drop_q && !redirect;
    push1           = push0 && !fetch_pc_q[2];
    push0_data      = {fetch_pc_q, fetch_pc_q[2] ? fq_rsp_data_i[DATA_W-1:INST_W]
                                                 : fq_rsp_data_i[INST_W-1:0]};
    push1_data      = {fetch_pc_q + DATA_W'(4), fq_rsp_data_i[DATA_W-1:INST_W]};
    pop             = fq_inst_valid_o && fq_inst_ready_i;
  end

  // Fetch FSM next state, fetch PC advance and stale-response drop tracking.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
`ifdef FQ_MISALIGN_CHK_EN
    misalign_d = misalign_q;
    if (redirect) misalign_d = target_bad;
`endif
    if (push0) fetch_pc_d = fetch_pc_q + (fetch_pc_q[2] ? DATA_W'(4) : DATA_W'(8));
    if (redirect) fetch_pc_d = target;
    case (state_q)
      FQ_ST_REQ: begin
        if (req_fire) begin
          state_d = FQ_ST_WAIT;
          drop_d  = redirect;
        end
`ifdef FQ_MISALIGN_CHK_EN
        else if (target_bad) begin
          state_d = FQ_ST_HALT;
        end
`endif
      end
      FQ_ST_WAIT: begin
        if (fq_rsp_valid_i) begin
          drop_d  = 1'b0;
          state_d = FQ_ST_REQ;
`ifdef FQ_MISALIGN_CHK_EN
          if (misalign_d) state_d = FQ_ST_HALT;
`endif
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
`ifdef FQ_MISALIGN_CHK_EN
      FQ_ST_HALT: begin
        if (redirect && !target_bad) state_d = FQ_ST_REQ;
      end
`endif
      default: state_d = FQ_ST_REQ;
    endcase
  end

  // FSM and fetch PC registers with synchronous reset.
  always_ff @(posedge fq_clk_i) begin
    if (fq_rst_i) begin
      state_q    <= FQ_ST_REQ;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
`ifdef FQ_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
`ifdef FQ_MISALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

`ifdef FQ_MISALIGN_CHK_EN
  assign fq_misalign_o = !fq_rst_i && misalign_q;
`endif

  ifu_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (fq_clk_i),
    .rst_i        (fq_rst_i),
    .flush_i      (redirect),
    .push0_i      (push0),
    .push1_i      (push1),
    .push0_data_i (push0_data),
    .push1_data_i (push1_data),
    .pop_i        (pop),
    .empty_o      (fifo_empty),
    .head_o       (head),
    .free_o       (free_cnt)
  );

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Self-checking bench for ifu_fetch_queue: directed scenarios followed by a
// randomized run, every cycle compared against a queue-based reference model.
// Build with FQ_MISALIGN_CHK_EN defined to cover the misalign flag.
module tb_ifu_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic        clock = 1'b0;
  logic        fq_rst_i, fq_req_ready_i, fq_rsp_valid_i;
  logic        fq_trap_flag_i, fq_branch_flag_i, fq_inst_ready_i;
  logic [63:0] fq_rsp_data_i, fq_trap_dnpc_i, fq_branch_dnpc_i;
  logic        fq_req_valid_o, fq_inst_valid_o;
  logic [63:0] fq_req_addr_o, fq_pc_o;
  logic [31:0] fq_inst_o;
`ifdef FQ_MISALIGN_CHK_EN
  logic        fq_misalign_o;
`endif

  int vectors     = 0;
  int miscompares = 0;

  entry_t      mQueue[$];
  logic [63:0] mFetchPc;
  bit          mOutstanding, mDrop, mInReset, mMisalign;

  always #5 clock = ~clock;

  ifu_fetch_queue dut (
    .fq_clk_i         (clock),
    .fq_rst_i         (fq_rst_i),
    .fq_req_valid_o   (fq_req_valid_o),
    .fq_req_ready_i   (fq_req_ready_i),
    .fq_req_addr_o    (fq_req_addr_o),
    .fq_rsp_valid_i   (fq_rsp_valid_i),
    .fq_rsp_data_i    (fq_rsp_data_i),
    .fq_trap_flag_i   (fq_trap_flag_i),
    .fq_trap_dnpc_i   (fq_trap_dnpc_i),
    .fq_branch_flag_i (fq_branch_flag_i),
    .fq_branch_dnpc_i (fq_branch_dnpc_i),
    .fq_inst_valid_o  (fq_inst_valid_o),
    .fq_inst_ready_i  (fq_inst_ready_i),
    .fq_inst_o        (fq_inst_o),
    .fq_pc_o          (fq_pc_o)
`ifdef FQ_MISALIGN_CHK_EN
    ,
    .fq_misalign_o    (fq_misalign_o)
`endif
  );

  // One comparison: count it, and report tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic bit modelReqValid();
    return !mInReset && !mOutstanding && !mMisalign && ((DEPTH - mQueue.size()) >= 2);
  endfunction

  function automatic bit modelInstValid();
    return !mInReset && (mQueue.size() != 0);
  endfunction

  // Compare every DUT output against the model's view of this cycle.
  task automatic compareModel();
    checkOutput("req_valid", 64'(fq_req_valid_o), 64'(modelReqValid()));
    if (modelReqValid())
      checkOutput("req_addr", fq_req_addr_o, {mFetchPc[63:3], 3'b000});
    checkOutput("inst_valid", 64'(fq_inst_valid_o), 64'(modelInstValid()));
    if (modelInstValid()) begin
      checkOutput("inst", 64'(fq_inst_o), 64'(mQueue[0].inst));
      checkOutput("pc", fq_pc_o, mQueue[0].pc);
    end
`ifdef FQ_MISALIGN_CHK_EN
    checkOutput("misalign", 64'(fq_misalign_o), 64'(mMisalign && !mInReset));
`endif
  endtask

  // Drive one cycle of inputs, check at the falling edge, advance the model,
  // and return just after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic rr, input logic rv,
                               input logic [63:0] rd, input logic tf,
                               input logic [63:0] td, input logic bf,
                               input logic [63:0] bd, input logic ir);
    logic [63:0] tgt;
    bit          redirect, fire, accepted, expValid;
    entry_t      e;
    fq_rst_i = rst;  fq_req_ready_i = rr;  fq_rsp_valid_i = rv;  fq_rsp_data_i = rd;
    fq_trap_flag_i = tf;  fq_trap_dnpc_i = td;  fq_branch_flag_i = bf;
    fq_branch_dnpc_i = bd;  fq_inst_ready_i = ir;
    @(negedge clock);
    mInReset = rst;
    compareModel();
    if (rst) begin
      mQueue.delete();
      mFetchPc     = RESET_PC;
      mOutstanding = 0;
      mDrop        = 0;
      mMisalign    = 0;
    end else begin
      redirect = tf || bf;
      tgt      = tf ? td : bd;
`ifndef FQ_MISALIGN_CHK_EN
      tgt[1:0] = 2'b00;
`endif
      fire     = modelReqValid() && rr;
      accepted = mOutstanding && rv;
      expValid = modelInstValid();
      if (redirect) begin
        mQueue.delete();
        mFetchPc = tgt;
`ifdef FQ_MISALIGN_CHK_EN
        mMisalign = (tgt[1:0] != 2'b00);
`endif
        if (fire) begin
          mOutstanding = 1;
          mDrop        = 1;
        end else if (accepted) begin
          mOutstanding = 0;
          mDrop        = 0;
        end else if (mOutstanding) begin
          mDrop = 1;
        end
      end else begin
        if (expValid && ir) void'(mQueue.pop_front());
        if (accepted) begin
          if (!mDrop) begin
            if (mFetchPc[2] == 1'b0) begin
              e.pc = mFetchPc;       e.inst = rd[31:0];  mQueue.push_back(e);
              e.pc = mFetchPc + 4;   e.inst = rd[63:32]; mQueue.push_back(e);
              mFetchPc = mFetchPc + 8;
            end else begin
              e.pc = mFetchPc;       e.inst = rd[63:32]; mQueue.push_back(e);
              mFetchPc = mFetchPc + 4;
            end
          end
          mOutstanding = 0;
          mDrop        = 0;
        end
        if (fire) mOutstanding = 1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [63:0] rndTrap, rndBranch;

    // Reset held for two cycles
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_req_valid", 64'(fq_req_valid_o), 64'd0);
    checkOutput("rst_inst_valid", 64'(fq_inst_valid_o), 64'd0);

    // First fetch after reset release, response one cycle later
    fq_rst_i = 1'b0;
    #1;
    checkOutput("rel_req_valid", 64'(fq_req_valid_o), 64'd1);
    checkOutput("rel_req_addr", fq_req_addr_o, 64'h8000_0000);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 64'hBBBB_BBBB_AAAA_AAAA, 0, 0, 0, 0, 0);
    checkOutput("first_inst", 64'(fq_inst_o), 64'hAAAA_AAAA);
    checkOutput("first_pc", fq_pc_o, 64'h8000_0000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("second_inst", 64'(fq_inst_o), 64'hBBBB_BBBB);
    checkOutput("second_pc", fq_pc_o, 64'h8000_0004);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("drained", 64'(fq_inst_valid_o), 64'd0);
    checkOutput("next_addr", fq_req_addr_o, 64'h8000_0008);

    // Branch to an odd-word target: single upper-half push
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h8000_0104, 0);
    checkOutput("br_addr", fq_req_addr_o, 64'h8000_0100);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 64'h2222_2222_1111_1111, 0, 0, 0, 0, 0);
    checkOutput("br_inst", 64'(fq_inst_o), 64'h2222_2222);
    checkOutput("br_pc", fq_pc_o, 64'h8000_0104);
    checkOutput("br_next_addr", fq_req_addr_o, 64'h8000_0108);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("br_single", 64'(fq_inst_valid_o), 64'd0);

    // Backpressure: queue fills to DEPTH, requests need two free entries
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1, 1, {$urandom, $urandom}, 0, 0, 0, 0, 0);
    checkOutput("full_req_valid", 64'(fq_req_valid_o), 64'd0);
    checkOutput("full_head_pc", fq_pc_o, 64'h8000_0108);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("three_req_valid", 64'(fq_req_valid_o), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("two_req_valid", 64'(fq_req_valid_o), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Branch while waiting: next response dropped
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h100, 1);
    applyStimulus(0, 0, 1, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, 0, 0);
    checkOutput("drop_inst_valid", 64'(fq_inst_valid_o), 64'd0);
    checkOutput("drop_req_valid", 64'(fq_req_valid_o), 64'd1);
    checkOutput("drop_addr", fq_req_addr_o, 64'h100);

    // Trap and branch together: trap wins, queue flushed, pop discarded
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 64'h0000_0004_0000_0003, 0, 0, 0, 0, 0);
    checkOutput("prefl_pc", fq_pc_o, 64'h100);
    applyStimulus(0, 0, 0, 0, 1, 64'h200, 1, 64'h300, 1);
    checkOutput("trap_inst_valid", 64'(fq_inst_valid_o), 64'd0);
    checkOutput("trap_addr", fq_req_addr_o, 64'h200);

    // Redirect coincident with response: discarded, no drop pending
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 64'h1234_5678_9ABC_DEF0, 0, 0, 1, 64'h400, 0);
    checkOutput("coinc_req_valid", 64'(fq_req_valid_o), 64'd1);
    checkOutput("coinc_addr", fq_req_addr_o, 64'h400);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 64'h0000_0006_0000_0005, 0, 0, 0, 0, 0);
    checkOutput("coinc_pc", fq_pc_o, 64'h400);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Redirect while the request is accepted: its response is dropped
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 64'h500, 0);
    applyStimulus(0, 0, 1, 64'h7777_7777_6666_6666, 0, 0, 0, 0, 0);
    checkOutput("acc_inst_valid", 64'(fq_inst_valid_o), 64'd0);
    checkOutput("acc_addr", fq_req_addr_o, 64'h500);

    // Reset during WAIT abandons the outstanding response
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 64'h9999_9999_8888_8888, 0, 0, 0, 0, 0);
    checkOutput("midrst_req_valid", 64'(fq_req_valid_o), 64'd0);
    applyStimulus(0, 0, 1, 64'h9999_9999_8888_8888, 0, 0, 0, 0, 0);
    checkOutput("postrst_addr", fq_req_addr_o, RESET_PC);
    checkOutput("postrst_inst_valid", 64'(fq_inst_valid_o), 64'd0);

`ifdef FQ_MISALIGN_CHK_EN
    // Misaligned branch halts fetch until an aligned redirect
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h102, 0);
    checkOutput("mis_flag", 64'(fq_misalign_o), 64'd1);
    checkOutput("mis_req_valid", 64'(fq_req_valid_o), 64'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_req_valid", 64'(fq_req_valid_o), 64'd0);
    applyStimulus(0, 0, 0, 0, 1, 64'h200, 0, 0, 0);
    checkOutput("unhalt_flag", 64'(fq_misalign_o), 64'd0);
    checkOutput("unhalt_addr", fq_req_addr_o, 64'h200);
`else
    // Low target bits are ignored without the misalign check
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h8000_0103, 0);
    checkOutput("mask_addr", fq_req_addr_o, 64'h8000_0100);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 2000; i++) begin
      rndTrap   = 64'h8000_0000 | 64'($urandom_range(0, 1023));
      rndBranch = 64'h8000_0000 | 64'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) rndTrap   = rndTrap   & ~64'd3;
      if ($urandom_range(0, 3) != 0) rndBranch = rndBranch & ~64'd3;
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) != 0,
                    {$urandom, $urandom},
                    $urandom_range(0, 29) == 0, rndTrap,
                    $urandom_range(0, 14) == 0, rndBranch,
                    $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
